muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide/remainder engine for the RV32M path.
- Consumes the ALU op one-hot bus and operand pair from the control unit, which pre-resolves signs into magnitudes.
- Returns a 64-bit result in the same format the control unit already slices from the ALU output.
- Replaces single-cycle combinational mul/div with a shift-add multiplier and a restoring divider, adding a start/busy/done handshake.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_unit.sv | 108 ++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide engine.
package muldiv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int MUL_BIT  = 10;
  localparam int DIV_BIT  = 11;
  localparam int REM_BIT  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            is_mul,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic            unused_diff;

  always_comb begin
    sum    = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
    rem_sh = {acc, lo[XLEN-1]};
    diff   = {1'b0, rem_sh} - {2'b00, opb};
    if (is_mul) begin
      acc_nxt = sum[XLEN:1];
      lo_nxt  = {sum[0], lo[XLEN-1:1]};
    end else if (!diff[XLEN+1]) begin
      // no borrow: the difference is below the divisor, so it fits in XLEN bits
      acc_nxt = diff[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = rem_sh[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], 1'b0};
    end
  end

  assign unused_diff = diff[XLEN];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned mul/div/rem with start/busy/done; done pulses 32 cycles after accept.
// Starts during RUN or with a non-one-hot op are dropped; no queuing.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [12:0]       instructions,
  input  logic [XLEN-1:0]   v1,
  input  logic [XLEN-1:0]   v2,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] result,
  output logic              div_by_zero
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d, lo_q, lo_d, opb_q, opb_d;
  logic              is_mul_q, is_mul_d, is_rem_q, is_rem_d;
  logic [2*XLEN-1:0] result_q, result_d;
  logic              dbz_q, dbz_d;
  logic [XLEN-1:0]   acc_nxt, lo_nxt;
  logic              accept;
  logic              unused_instr;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_mul  (is_mul_q),
    .acc     (acc_q),
    .lo      (lo_q),
    .opb     (opb_q),
    .acc_nxt (acc_nxt),
    .lo_nxt  (lo_nxt)
  );

  assign accept = start && (state_q != RUN) && $onehot(instructions[REM_BIT:MUL_BIT]);
  assign unused_instr = ^instructions[MUL_BIT-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    is_mul_d = is_mul_q;
    is_rem_d = is_rem_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      RUN: begin
        acc_d = acc_nxt;
        lo_d  = lo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = DONE;
          dbz_d   = !is_mul_q && (opb_q == '0);
          if (is_mul_q) result_d = {acc_nxt, lo_nxt};
          else          result_d = {{XLEN{1'b0}}, (is_rem_q ? acc_nxt : lo_nxt)};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // accept overrides the DONE->IDLE step so back-to-back ops lose no cycle
    if (accept) begin
      state_d  = RUN;
      cnt_d    = '0;
      acc_d    = '0;
      lo_d     = v1;
      opb_d    = v2;
      is_mul_d = instructions[MUL_BIT];
      is_rem_d = instructions[REM_BIT];
      dbz_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      is_mul_q <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      is_mul_q <= is_mul_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] instructions;
  logic [31:0] v1, v2;
  logic        busy, done, div_by_zero;
  logic [63:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [12:0] OP_MUL = 13'd1024;
  localparam logic [12:0] OP_DIV = 13'd2048;
  localparam logic [12:0] OP_REM = 13'd4096;

  muldiv_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .instructions (instructions),
    .v1           (v1),
    .v2           (v2),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned arithmetic with RISC-V divide-by-zero results.
  function automatic logic [63:0] model(input logic [12:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (ins == OP_MUL)      r = {32'd0, a} * {32'd0, b};
    else if (ins == OP_DIV) r = (b == 0) ? 64'h0000_0000_FFFF_FFFF : {32'd0, a / b};
    else                    r = (b == 0) ? {32'd0, a} : {32'd0, a % b};
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (the DONE cycle).
  // lat = clock edges from the accept edge to done; -1 on timeout.
  task automatic run_op(input logic [12:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, output int lat, output int bcnt);
    start = 1'b1; instructions = ins; v1 = a; v2 = b;
    @(negedge clk);
    start = 1'b0; lat = -1; bcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = k - 1;
        break;
      end
      if (k == inj_at) begin
        start = 1'b1; instructions = OP_DIV; v1 = $urandom; v2 = $urandom_range(1, 9);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp += 4;
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    if (result !== 64'd0)     begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
  endtask

  task automatic test_directed;
    logic [12:0] ins [5] = '{OP_MUL, OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [31:0] a   [5] = '{32'hFFFF_FFFF, 32'd100, 32'd100, 32'h1234_5678, 32'h1234_5678};
    logic [31:0] b   [5] = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [63:0] want[5] = '{64'hFFFF_FFFE_0000_0001, 64'h0E, 64'h02, 64'hFFFF_FFFF, 64'h1234_5678};
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      run_op(ins[i], a[i], b[i], 0, lat, bcnt);
      n_cmp += 4;
      if (lat != 32)            begin n_fail++; $display("FAIL dir%0d_latency got %0d want 32", i, lat); end
      if (bcnt != 32)           begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want 32", i, bcnt); end
      if (result !== want[i])   begin n_fail++; $display("FAIL dir%0d_result got %h want %h", i, result, want[i]); end
      if (div_by_zero !== (b[i] == 0)) begin n_fail++; $display("FAIL dir%0d_dbz got %b want %b", i, div_by_zero, b[i] == 0); end
      @(negedge clk);
      n_cmp += 3;
      if (done !== 1'b0)        begin n_fail++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
      if (result !== want[i])   begin n_fail++; $display("FAIL dir%0d_result_hold got %h want %h", i, result, want[i]); end
      if (div_by_zero !== (b[i] == 0)) begin n_fail++; $display("FAIL dir%0d_dbz_hold got %b want %b", i, div_by_zero, b[i] == 0); end
    end
  endtask

  task automatic test_random;
    logic [12:0] ops [3] = '{OP_MUL, OP_DIV, OP_REM};
    logic [12:0] ins;
    logic [31:0] a, b;
    int lat, bcnt;
    for (int i = 0; i < 24; i++) begin
      ins = ops[$urandom_range(0, 2)];
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = a;
        default: b = $urandom;
      endcase
      run_op(ins, a, b, 0, lat, bcnt);
      n_cmp += 3;
      if (lat != 32) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want 32", i, lat); end
      if (result !== model(ins, a, b)) begin
        n_fail++; $display("FAIL rnd%0d_result op=%h a=%h b=%h got %h want %h", i, ins, a, b, result, model(ins, a, b));
      end
      if (div_by_zero !== (ins != OP_MUL && b == 0)) begin
        n_fail++; $display("FAIL rnd%0d_dbz got %b want %b", i, div_by_zero, ins != OP_MUL && b == 0);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_start_during_run;
    int lat, bcnt;
    run_op(OP_MUL, 32'd3, 32'd5, 5, lat, bcnt);
    n_cmp += 2;
    if (lat != 32)        begin n_fail++; $display("FAIL run_start_latency got %0d want 32", lat); end
    if (result !== 64'd15) begin n_fail++; $display("FAIL run_start_result got %h want 15", result); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0)    begin n_fail++; $display("FAIL run_start_no_requeue busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt, held_bad;
    run_op(OP_MUL, 32'd3, 32'd5, 0, lat, bcnt);
    n_cmp++;
    if (result !== 64'd15) begin n_fail++; $display("FAIL b2b_first got %h want 15", result); end
    held_bad = 0;
    start = 1'b1; instructions = OP_DIV; v1 = 32'h8000_0000; v2 = 32'd2;
    @(negedge clk);
    start = 1'b0; lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin lat = k - 1; break; end
      if (result !== 64'd15) held_bad++;
      @(negedge clk);
    end
    n_cmp += 3;
    if (lat != 32)      begin n_fail++; $display("FAIL b2b_latency got %0d want 32", lat); end
    if (held_bad != 0)  begin n_fail++; $display("FAIL b2b_result_hold got %0d bad cycles want 0", held_bad); end
    if (result !== 64'h4000_0000) begin n_fail++; $display("FAIL b2b_second got %h want 40000000", result); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    logic [12:0] bad [3] = '{13'd1, 13'h0C00, 13'h1C00};
    int seen;
    for (int i = 0; i < 3; i++) begin
      seen = 0;
      start = 1'b1; instructions = bad[i]; v1 = $urandom; v2 = $urandom;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 36; k++) begin
        if (busy || done) seen++;
        @(negedge clk);
      end
      n_cmp++;
      if (seen != 0) begin n_fail++; $display("FAIL illegal%0d busy_or_done got %0d cycles want 0", i, seen); end
    end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    start = 1'b1; instructions = OP_MUL; v1 = 32'hDEAD_BEEF; v2 = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp += 3;
    if (busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (done !== 1'b0)    begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
    if (result !== 64'd0) begin n_fail++; $display("FAIL midrst_result got %h want 0", result); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy || done) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d cycles want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; instructions = '0; v1 = '0; v2 = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_directed();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_illegal();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
